// File: rtl/pwm_peripheral_if.sv
// Configuration bundle from the SPI register block into the PWM peripheral.
// master = register block side, slave = PWM peripheral side.
interface pwm_peripheral_if;
    logic [7:0] en_reg_out_7_0;
    logic [7:0] en_reg_out_15_8;
    logic [7:0] en_reg_pwm_7_0;
    logic [7:0] en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle;

    modport master (
        output en_reg_out_7_0,
        output en_reg_out_15_8,
        output en_reg_pwm_7_0,
        output en_reg_pwm_15_8,
        output pwm_duty_cycle
    );

    modport slave (
        input en_reg_out_7_0,
        input en_reg_out_15_8,
        input en_reg_pwm_7_0,
        input en_reg_pwm_15_8,
        input pwm_duty_cycle
    );
endinterface

// File: rtl/pwm_peripheral.sv
// 16-pin output driver: each pin off, static high, or a shared PWM waveform
// with a 255-tick period and a duty value double-buffered at period boundaries.
module pwm_peripheral #(
    parameter int CLK_DIV = 13
) (
    input  logic             clk,
    input  logic             rst,
    pwm_peripheral_if.slave  cfg,
    output logic [15:0]      out,
    output logic             period_start
);
    localparam int             PW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0]  PRE_LAST = PW'(CLK_DIV - 1);
    localparam logic [7:0]     CNT_LAST = 8'd254;

    logic [PW-1:0] prescaler;
    logic [PW-1:0] prescaler_nxt;
    logic [7:0]    pwm_cnt;
    logic [7:0]    pwm_cnt_nxt;
    logic [7:0]    duty_shadow;
    logic [7:0]    duty_shadow_nxt;
    logic          tick;
    logic          boundary;
    logic          level_nxt;
    logic [15:0]   en_out;
    logic [15:0]   en_pwm;

    assign en_out = {cfg.en_reg_out_15_8, cfg.en_reg_out_7_0};
    assign en_pwm = {cfg.en_reg_pwm_15_8, cfg.en_reg_pwm_7_0};

    always_comb begin
        tick            = (prescaler == PRE_LAST);
        boundary        = tick && (pwm_cnt == CNT_LAST);
        prescaler_nxt   = tick ? '0 : prescaler + PW'(1);
        pwm_cnt_nxt     = pwm_cnt;
        if (tick) begin
            pwm_cnt_nxt = boundary ? 8'd0 : pwm_cnt + 8'd1;
        end
        duty_shadow_nxt = boundary ? cfg.pwm_duty_cycle : duty_shadow;
        // Level is taken from next-state counter/shadow so the first pin value
        // of a new period lands on the same edge as period_start.
        level_nxt       = (duty_shadow_nxt == 8'hFF) || (pwm_cnt_nxt < duty_shadow_nxt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler    <= '0;
            pwm_cnt      <= 8'd0;
            duty_shadow  <= 8'h00;
            out          <= 16'h0000;
            period_start <= 1'b0;
        end else begin
            prescaler    <= prescaler_nxt;
            pwm_cnt      <= pwm_cnt_nxt;
            duty_shadow  <= duty_shadow_nxt;
            out          <= en_out & (~en_pwm | {16{level_nxt}});
            period_start <= boundary;
        end
    end
endmodule

// File: tb/tb_pwm_peripheral.sv
// Directed self-checking bench for pwm_peripheral at CLK_DIV=2 (510 clk period).
module tb_pwm_peripheral;
    localparam int CLK_DIV = 2;
    localparam int PERIOD  = 255 * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] out;
    logic        period_start;
    int          checks = 0;
    int          errors = 0;

    pwm_peripheral_if cfg_if ();

    pwm_peripheral #(.CLK_DIV(CLK_DIV)) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg          (cfg_if),
        .out          (out),
        .period_start (period_start)
    );

    always #5 clk = ~clk;

    task automatic set_cfg(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] duty);
        cfg_if.en_reg_out_7_0  = eo[7:0];
        cfg_if.en_reg_out_15_8 = eo[15:8];
        cfg_if.en_reg_pwm_7_0  = ep[7:0];
        cfg_if.en_reg_pwm_15_8 = ep[15:8];
        cfg_if.pwm_duty_cycle  = duty;
    endtask

    // Advance at least one cycle, stop on the sample where period_start is high.
    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < PERIOD + 20; n++) begin
            @(negedge clk);
            if (period_start === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Release reset and count cycles to the first period_start, tallying non-zero outputs.
    task automatic release_and_count(output int n, output int nonzero);
        n       = -1;
        nonzero = 0;
        rst     = 1'b0;
        for (int k = 1; k <= PERIOD + 20; k++) begin
            @(negedge clk);
            if (period_start === 1'b1) begin
                n = k;
                break;
            end
            if (out !== 16'h0000) nonzero++;
        end
    endtask

    // Observe one full period starting on a period_start sample.
    task automatic measure(input int bit_idx, input bit chk_hi, input logic [7:0] hi_exp,
                           input int chg_at, input logic [7:0] chg_val,
                           output int high, output int first_low, output int extra_ps,
                           output int hi_bad, output logic next_ps);
        high      = 0;
        first_low = -1;
        extra_ps  = 0;
        hi_bad    = 0;
        for (int i = 0; i < PERIOD; i++) begin
            if (i == chg_at) cfg_if.pwm_duty_cycle = chg_val;
            if (out[bit_idx] === 1'b1) high++;
            else if (first_low < 0) first_low = i;
            if (i > 0 && period_start !== 1'b0) extra_ps++;
            if (chk_hi && out[15:8] !== hi_exp) hi_bad++;
            @(negedge clk);
        end
        next_ps = period_start;
    endtask

    task automatic test_reset;
        int n, nz, high, fl, xps, hb;
        logic nps;
        set_cfg(16'hFFFF, 16'hFFFF, 8'h80);
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++; if (out !== 16'h0000) begin errors++; $display("FAIL reset_out: got %h want 0000", out); end
            checks++; if (period_start !== 1'b0) begin errors++; $display("FAIL reset_ps: got %b want 0", period_start); end
        end
        release_and_count(n, nz);
        checks++; if (n != PERIOD) begin errors++; $display("FAIL reset_first_start: got %0d want %0d", n, PERIOD); end
        checks++; if (nz != 0) begin errors++; $display("FAIL reset_first_period_low: got %0d nonzero cycles want 0", nz); end
        measure(0, 1'b0, 8'h00, -1, 8'h00, high, fl, xps, hb, nps);
        checks++; if (high != 256) begin errors++; $display("FAIL reset_second_high: got %0d want 256", high); end
        checks++; if (fl != 256) begin errors++; $display("FAIL reset_second_first_low: got %0d want 256", fl); end
    endtask

    task automatic test_static_pwm;
        bit ok;
        int high, fl, xps, hb;
        logic nps;
        set_cfg(16'hFFFF, 16'h00FF, 8'h80);
        wait_start(ok);
        checks++; if (!ok) begin errors++; $display("FAIL static_wait: got no period_start want one"); end
        measure(3, 1'b1, 8'hFF, -1, 8'h00, high, fl, xps, hb, nps);
        checks++; if (high != 256) begin errors++; $display("FAIL static_pwm_high: got %0d want 256", high); end
        checks++; if (fl != 256) begin errors++; $display("FAIL static_pwm_first_low: got %0d want 256", fl); end
        checks++; if (hb != 0) begin errors++; $display("FAIL static_hi_pins: got %0d bad cycles want 0", hb); end
        checks++; if (xps != 0) begin errors++; $display("FAIL static_extra_ps: got %0d want 0", xps); end
        checks++; if (nps !== 1'b1) begin errors++; $display("FAIL static_ps_spacing: got %b want 1 at 510", nps); end
    endtask

    task automatic test_duty_extremes;
        logic [7:0] duties [3];
        int         exp_high [3];
        int         exp_fl [3];
        bit         ok;
        int         high, fl, xps, hb;
        logic       nps;
        duties = '{8'h00, 8'hFF, 8'h01};
        exp_high = '{0, PERIOD, CLK_DIV};
        exp_fl   = '{0, -1, CLK_DIV};
        for (int t = 0; t < 3; t++) begin
            cfg_if.pwm_duty_cycle = duties[t];
            wait_start(ok);
            checks++; if (!ok) begin errors++; $display("FAIL extremes_wait_%0d: got no period_start want one", t); end
            measure(7, 1'b1, 8'hFF, -1, 8'h00, high, fl, xps, hb, nps);
            checks++; if (high != exp_high[t]) begin errors++; $display("FAIL extremes_high duty=%h: got %0d want %0d", duties[t], high, exp_high[t]); end
            checks++; if (fl != exp_fl[t]) begin errors++; $display("FAIL extremes_first_low duty=%h: got %0d want %0d", duties[t], fl, exp_fl[t]); end
            checks++; if (hb != 0) begin errors++; $display("FAIL extremes_hi_pins duty=%h: got %0d want 0", duties[t], hb); end
        end
    endtask

    task automatic test_mid_update;
        bit ok;
        int high, fl, xps, hb;
        logic nps;
        cfg_if.pwm_duty_cycle = 8'h40;
        wait_start(ok);
        checks++; if (!ok) begin errors++; $display("FAIL mid_wait: got no period_start want one"); end
        measure(0, 1'b0, 8'h00, 10 * CLK_DIV, 8'hC0, high, fl, xps, hb, nps);
        checks++; if (high != 64 * CLK_DIV) begin errors++; $display("FAIL mid_current_high: got %0d want %0d", high, 64 * CLK_DIV); end
        checks++; if (nps !== 1'b1) begin errors++; $display("FAIL mid_next_start: got %b want 1", nps); end
        measure(0, 1'b0, 8'h00, -1, 8'h00, high, fl, xps, hb, nps);
        checks++; if (high != 192 * CLK_DIV) begin errors++; $display("FAIL mid_next_high: got %0d want %0d", high, 192 * CLK_DIV); end
        checks++; if (fl != 192 * CLK_DIV) begin errors++; $display("FAIL mid_next_first_low: got %0d want %0d", fl, 192 * CLK_DIV); end
    endtask

    task automatic test_enable_override;
        bit ok;
        int bad;
        set_cfg(16'h0000, 16'hFFFF, 8'hFF);
        wait_start(ok);
        checks++; if (!ok) begin errors++; $display("FAIL override_wait: got no period_start want one"); end
        bad = 0;
        repeat (37) begin
            if (out !== 16'h0000) bad++;
            @(negedge clk);
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL override_all_off: got %0d nonzero cycles want 0", bad); end
        cfg_if.en_reg_out_7_0 = 8'h20;
        checks++; if (out !== 16'h0000) begin errors++; $display("FAIL override_before_edge: got %h want 0000", out); end
        @(negedge clk);
        checks++; if (out !== 16'h0020) begin errors++; $display("FAIL override_bit5: got %h want 0020", out); end
    endtask

    task automatic test_reset_mid;
        bit ok;
        int n, nz, high, fl, xps, hb;
        logic nps;
        set_cfg(16'hFFFF, 16'hFFFF, 8'h80);
        wait_start(ok);
        checks++; if (!ok) begin errors++; $display("FAIL rstmid_wait: got no period_start want one"); end
        repeat (100 * CLK_DIV) @(negedge clk);
        checks++; if (out !== 16'hFFFF) begin errors++; $display("FAIL rstmid_before: got %h want ffff", out); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (out !== 16'h0000) begin errors++; $display("FAIL rstmid_out: got %h want 0000", out); end
        checks++; if (period_start !== 1'b0) begin errors++; $display("FAIL rstmid_ps: got %b want 0", period_start); end
        @(negedge clk);
        release_and_count(n, nz);
        checks++; if (n != PERIOD) begin errors++; $display("FAIL rstmid_first_start: got %0d want %0d", n, PERIOD); end
        checks++; if (nz != 0) begin errors++; $display("FAIL rstmid_first_period_low: got %0d nonzero cycles want 0", nz); end
        measure(0, 1'b0, 8'h00, -1, 8'h00, high, fl, xps, hb, nps);
        checks++; if (high != 256) begin errors++; $display("FAIL rstmid_second_high: got %0d want 256", high); end
    endtask

    initial begin
        test_reset();
        test_static_pwm();
        test_duty_extremes();
        test_mid_update();
        test_enable_override();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pwm_peripheral.md
Name: pwm_peripheral

Overview:
- Consumes the five configuration registers produced by the SPI register block: output enables, PWM-mode enables and the duty cycle.
- Drives 16 output pins. Each pin is forced low, held static high, or driven by a shared PWM waveform.
- A single 8-bit duty cycle is shared by all PWM-mode pins. The duty value is double-buffered so that register writes never glitch a period in progress.
- Sits directly downstream of the SPI register block and directly upstream of the chip output pads.

Parameters:
- CLK_DIV, 13: clk cycles per PWM tick; legal range ≥1. The period is 255 ticks, giving ≈3.02 kHz at 10 MHz.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- en_reg_out_7_0  in  8  output enable for pins 7..0; 1 = pin active.
- en_reg_out_15_8  in  8  output enable for pins 15..8.
- en_reg_pwm_7_0  in  8  PWM-mode select for pins 7..0; 1 = PWM, 0 = static high.
- en_reg_pwm_15_8  in  8  PWM-mode select for pins 15..8.
- pwm_duty_cycle  in  8  requested duty, 0x00..0xFF.
- out  out  16  pin drive; bit i corresponds to pin i.
- period_start  out  1  single-cycle pulse marking the first clk of each PWM period.

Behaviour:
- Reset (rst=1 at a clk edge): prescaler=0, pwm_cnt=0, duty_shadow=0x00, out=16'h0000, period_start=0. Reset mid-period aborts the period immediately; there is no partial-period completion.
- Prescaler:
  - Width is max(1,$clog2(CLK_DIV)) bits.
  - Counts 0..CLK_DIV-1, then wraps to 0.
  - tick = (prescaler==CLK_DIV-1).
  - CLK_DIV=1: tick asserts every cycle.
- Period counter pwm_cnt, 8 bits:
  - On each tick: if pwm_cnt==254, wrap to 0; otherwise increment.
  - Value 255 is never reached. Period = 255 ticks = 255*CLK_DIV clk.
- Duty shadow:
  - Boundary event = tick && pwm_cnt==254.
  - On a boundary event, duty_shadow <= pwm_duty_cycle.
  - No other updates. A duty change mid-period takes effect at the next period start.
  - After reset, the first period always runs with duty 0x00.
- PWM level (combinational from current state):
  - duty_shadow==0xFF: level=1, always high with no low tick.
  - Otherwise: level = (pwm_cnt < duty_shadow).
  - Resulting high time is duty_shadow ticks out of 255; duty 0x00 gives constant low.
- Pin mapping, registered (one clk latency from any input or state change):
  - out[i] <= en_out[i] ? (en_pwm[i] ? level : 1'b1) : 1'b0
  - en_out = {en_reg_out_15_8, en_reg_out_7_0}; en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0}.
  - Enable and mode changes are not synchronised to the period. They take effect on the next clk.
  - en_out=0 overrides en_pwm.
- period_start: registered. It is 1 in the clk cycle following a boundary event, coincident with the first out value computed from pwm_cnt==0 and the new duty_shadow. Otherwise it is 0.
- Inputs are treated as already synchronous to clk; the SPI block drives them from clk-domain registers. No additional synchronisers.
- Simultaneous duty change and boundary event: the value present on pwm_duty_cycle in that cycle is captured.
- All pins in PWM mode share phase; there is no per-pin offset.

Test Plan:
- Reset behaviour: CLK_DIV=2, assert rst for 3 cycles with all enables=0xFF and duty=0x80 -> out=0x0000 and period_start=0 during reset. The first period after reset stays low on all PWM pins because duty_shadow=0.
- Static and PWM mode: en_out=16'hFFFF, en_pwm=16'h00FF, duty=0x80, CLK_DIV=2 -> pins 15..8 constantly 1. From the second period on, pins 7..0 are high for 256 clk then low for 254 clk. Consecutive period_start pulses are 510 clk apart.
- Duty extremes: duty=0x00 -> PWM pins constantly 0 for full periods. duty=0xFF -> PWM pins constantly 1 with no low cycle. duty=0x01 -> high for exactly CLK_DIV clk per period.
- Mid-period update: duty=0x40, then change to 0xC0 when pwm_cnt=10 -> the current period keeps high time 64 ticks. The next period has high time 192 ticks, starting at the period_start pulse.
- Enable override: en_out=0x0000, en_pwm=0xFFFF, duty=0xFF -> out=0x0000. Setting en_out bit 5 at an arbitrary cycle N -> out[5]=1 at cycle N+1 with no other bits affected.
- Reset mid-operation: assert rst at pwm_cnt=100 with duty_shadow=0x80 -> out=0 on the next clk. After release, pwm_cnt restarts at 0 and the first period is low on PWM pins.
